// File: rtl/testbasic8_feeder_types.sv
// Shared types and constants for the TestBasic8 feeder.
package testbasic8_feeder_types;

  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } TestBasic8_feeder_SECTIONS;

endpackage

// File: rtl/feeder_fifo.sv
// Show-ahead FIFO with power-of-two depth; head word is visible on dout while not empty.
module feeder_fifo
  import testbasic8_feeder_types::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              do_push;
  logic              do_pop;

  // A push into a full FIFO is legal only when a pop frees the slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/testbasic8_feeder.sv
// Offset-adding producer feeding TestBasic8 over a sync/notify handshake.
// Define TESTBASIC8_FEEDER_SAT_EN to saturate the offset sum instead of wrapping.
module testbasic8_feeder
  import testbasic8_feeder_types::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int          OFFSET = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a_in,
  input  logic        a_in_sync,
  output logic        a_in_notify,
  input  logic        m_en,
  output logic [31:0] b_out,
  input  logic        b_out_sync,
  output logic        b_out_notify,
  output logic [31:0] count_out
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam logic [31:0] OFFSET_W = 32'(OFFSET);

  TestBasic8_feeder_SECTIONS section;

  logic              full;
  logic              empty;
  logic [LVL_W-1:0]  level;
  logic              push;
  logic              pop;
  logic              drain_done;
  logic [32:0]       sum;
  logic [31:0]       wdata;

  assign a_in_notify  = (section == RUN) && !full;
  assign b_out_notify = !empty;
  assign push         = a_in_sync && a_in_notify;
  assign pop          = b_out_notify && b_out_sync;
  assign drain_done   = empty || ((level == LVL_W'(1)) && pop);

  // Sign-extend both operands so bit 32 exposes signed overflow.
  assign sum = {a_in[31], a_in} + {OFFSET_W[31], OFFSET_W};

`ifdef TESTBASIC8_FEEDER_SAT_EN
  always_comb begin
    wdata = sum[31:0];
    if (sum[32] != sum[31]) begin
      wdata = sum[32] ? INT_MIN : INT_MAX;
    end
  end
`else
  logic sum_msb_unused;
  assign sum_msb_unused = sum[32];
  assign wdata          = sum[31:0];
`endif

  feeder_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (wdata),
    .dout  (b_out),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Intake section control and delivered-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      section   <= IDLE;
      count_out <= '0;
    end else begin
      if (pop) begin
        count_out <= count_out + 32'd1;
      end
      case (section)
        IDLE: begin
          if (m_en) section <= RUN;
        end
        RUN: begin
          if (!m_en) section <= empty ? IDLE : DRAIN;
        end
        DRAIN: begin
          if (m_en)            section <= RUN;
          else if (drain_done) section <= IDLE;
        end
        default: section <= IDLE;
      endcase
    end
  end

endmodule
